// File: rtl/trigger_scheduler_pkg.sv
// Shared types and constants for the ADS868x trigger scheduler.
package trigger_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_OFF = 2'd0,
    MODE_EXT = 2'd1,
    MODE_PTP = 2'd2,
    MODE_RTC = 2'd3
  } trig_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_ISSUE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned MIN_PERIOD = 2;

  // 64-bit unsigned {sec,ns} comparison: live time has reached the target
  function automatic logic rtc_reached(input logic [31:0] sec, input logic [31:0] ns,
                                       input logic [31:0] tgt_sec, input logic [31:0] tgt_ns);
    return {sec, ns} >= {tgt_sec, tgt_ns};
  endfunction

endpackage

// File: rtl/trigger_scheduler_edge.sv
// trig_edge_sync: 2-FF synchronizer plus registered rising-edge pulse (valid 3 clk after pin edge).
module trig_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_q;
  logic r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_q <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
      r_pulse  <= r_sync & ~r_sync_q;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/trigger_scheduler.sv
// Arms on enable, waits for ext/PTP/RTC trigger, then issues a burst of adc_start pulses.
// Optional `TRIG_TIMESTAMP_EN adds a timestamp of the fire cycle (ts_sec/ts_ns/ts_valid).
module trigger_scheduler
  import trigger_scheduler_pkg::*;
#(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_enable,
  input  logic [1:0]         cfg_mode,
  input  logic [31:0]        cfg_rtc_sec,
  input  logic [31:0]        cfg_rtc_ns,
  input  logic [BURST_W-1:0] cfg_burst_len,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [31:0]        rtc_sec,
  input  logic [31:0]        rtc_ns,
  input  logic               ext_trigger,
  input  logic               ptp_trigger,
  input  logic               adc_busy,
  output logic               adc_start,
  output logic [2:0]         sts_state,
  output logic               sts_late,
  output logic [15:0]        sts_overrun,
`ifdef TRIG_TIMESTAMP_EN
  output logic [31:0]        ts_sec,
  output logic [31:0]        ts_ns,
  output logic               ts_valid,
`endif
  output logic               irq_done
);

  localparam int unsigned OVR_W = 16;
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_enable_q;
  trig_mode_t         r_mode;
  logic [31:0]        r_tgt_sec;
  logic [31:0]        r_tgt_ns;
  logic [BURST_W-1:0] r_burst_len;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_period_cnt;
  logic [BURST_W-1:0] r_sample_cnt;
  logic [OVR_W-1:0]   r_overrun;
  logic               r_late;
  logic               r_adc_start;
  logic               r_irq_done;

  logic w_ext_pulse;
  logic w_ptp_pulse;
  logic w_arm;
  logic w_fire;
  logic w_start;
  logic w_expire;
  logic [CNT_W-1:0] w_period_load;

  trig_edge_sync u_ext_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ext_trigger),
    .o_pulse (w_ext_pulse)
  );

  trig_edge_sync u_ptp_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ptp_trigger),
    .o_pulse (w_ptp_pulse)
  );

  // GAP holds period-1 cycles; the ISSUE cycle completes the spacing
  assign w_period_load = ((r_period < MIN_P) ? MIN_P : r_period) - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_fire      = 1'b0;
    w_start     = 1'b0;
    w_expire    = 1'b0;
    if (!cfg_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_enable_q) begin
            w_arm       = 1'b1;
            w_state_nxt = ST_ARMED;
          end
        end
        ST_ARMED: begin
          case (r_mode)
            MODE_EXT: w_fire = w_ext_pulse;
            MODE_PTP: w_fire = w_ptp_pulse;
            MODE_RTC: w_fire = rtc_reached(rtc_sec, rtc_ns, r_tgt_sec, r_tgt_ns);
            default:  w_fire = 1'b0;
          endcase
          if (w_fire) w_state_nxt = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!adc_busy) begin
            w_start     = 1'b1;
            w_state_nxt = ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_period_cnt <= CNT_W'(1)) begin
            w_expire = 1'b1;
            if ((r_burst_len != '0) && (r_sample_cnt == r_burst_len)) w_state_nxt = ST_DONE;
            else                                                      w_state_nxt = ST_ISSUE;
          end
        end
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable_q   <= 1'b0;
      r_mode       <= MODE_OFF;
      r_tgt_sec    <= '0;
      r_tgt_ns     <= '0;
      r_burst_len  <= '0;
      r_period     <= '0;
      r_period_cnt <= '0;
      r_sample_cnt <= '0;
      r_overrun    <= '0;
      r_late       <= 1'b0;
      r_adc_start  <= 1'b0;
      r_irq_done   <= 1'b0;
    end else begin
      r_enable_q  <= cfg_enable;
      r_adc_start <= w_start;
      r_irq_done  <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
      if (w_arm) begin
        r_mode       <= trig_mode_t'(cfg_mode);
        r_tgt_sec    <= cfg_rtc_sec;
        r_tgt_ns     <= cfg_rtc_ns;
        r_burst_len  <= cfg_burst_len;
        r_period     <= cfg_period;
        r_sample_cnt <= '0;
        r_overrun    <= '0;
        r_late       <= (trig_mode_t'(cfg_mode) == MODE_RTC) &&
                        rtc_reached(rtc_sec, rtc_ns, cfg_rtc_sec, cfg_rtc_ns);
      end
      if (w_start) begin
        r_sample_cnt <= r_sample_cnt + BURST_W'(1);
        r_period_cnt <= w_period_load;
      end else if (r_state == ST_GAP) begin
        r_period_cnt <= r_period_cnt - CNT_W'(1);
      end
      if (w_expire && adc_busy && (r_overrun != '1)) r_overrun <= r_overrun + OVR_W'(1);
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] r_ts_sec;
  logic [31:0] r_ts_ns;
  logic        r_ts_valid;

  // Live RTC captured on the fire cycle; valid persists until the next arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts_sec   <= '0;
      r_ts_ns    <= '0;
      r_ts_valid <= 1'b0;
    end else if (w_arm) begin
      r_ts_valid <= 1'b0;
    end else if (w_fire) begin
      r_ts_sec   <= rtc_sec;
      r_ts_ns    <= rtc_ns;
      r_ts_valid <= 1'b1;
    end
  end

  assign ts_sec   = r_ts_sec;
  assign ts_ns    = r_ts_ns;
  assign ts_valid = r_ts_valid;
`endif

  assign adc_start   = r_adc_start;
  assign sts_state   = r_state;
  assign sts_late    = r_late;
  assign sts_overrun = r_overrun;
  assign irq_done    = r_irq_done;

endmodule

// File: tb/tb_trigger_scheduler.sv
// Directed self-checking bench for trigger_scheduler (timestamp test when TRIG_TIMESTAMP_EN set).
module tb_trigger_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_enable;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_rtc_sec;
  logic [31:0] cfg_rtc_ns;
  logic [15:0] cfg_burst_len;
  logic [23:0] cfg_period;
  logic [31:0] rtc_sec;
  logic [31:0] rtc_ns;
  logic        ext_trigger;
  logic        ptp_trigger;
  logic        adc_busy;
  logic        adc_start;
  logic [2:0]  sts_state;
  logic        sts_late;
  logic [15:0] sts_overrun;
  logic        irq_done;
`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] ts_sec;
  logic [31:0] ts_ns;
  logic        ts_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  trigger_scheduler #(.CNT_W(24), .BURST_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_enable    (cfg_enable),
    .cfg_mode      (cfg_mode),
    .cfg_rtc_sec   (cfg_rtc_sec),
    .cfg_rtc_ns    (cfg_rtc_ns),
    .cfg_burst_len (cfg_burst_len),
    .cfg_period    (cfg_period),
    .rtc_sec       (rtc_sec),
    .rtc_ns        (rtc_ns),
    .ext_trigger   (ext_trigger),
    .ptp_trigger   (ptp_trigger),
    .adc_busy      (adc_busy),
    .adc_start     (adc_start),
    .sts_state     (sts_state),
    .sts_late      (sts_late),
    .sts_overrun   (sts_overrun),
`ifdef TRIG_TIMESTAMP_EN
    .ts_sec        (ts_sec),
    .ts_ns         (ts_ns),
    .ts_valid      (ts_valid),
`endif
    .irq_done      (irq_done)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disarm();
    cfg_enable  = 1'b0;
    ext_trigger = 1'b0;
    ptp_trigger = 1'b0;
    adc_busy    = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_enable = 1'b0; cfg_mode = 2'd0; cfg_rtc_sec = '0; cfg_rtc_ns = '0;
    cfg_burst_len = '0; cfg_period = '0; rtc_sec = '0; rtc_ns = '0;
    ext_trigger = 1'b0; ptp_trigger = 1'b0; adc_busy = 1'b0;
    repeat (3) tick();
    checks++;
    if ({adc_start, sts_state, sts_late, sts_overrun, irq_done} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got start=%b state=%0d late=%b ovr=%0d irq=%b exp all 0",
               adc_start, sts_state, sts_late, sts_overrun, irq_done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ext_burst();
    int st[4];
    int n_start = 0;
    int n_irq = 0;
    int irq_at = -1;
    for (int i = 0; i < 4; i++) st[i] = -1;
    cfg_mode = 2'd1; cfg_burst_len = 16'd4; cfg_period = 24'd100; cfg_enable = 1'b1;
    tick();
    checks++;
    if (sts_state !== 3'd1) begin
      errors++; $display("FAIL ext_armed state got %0d exp 1", sts_state);
    end
    ext_trigger = 1'b1;
    for (int c = 1; c <= 450; c++) begin
      tick();
      if (adc_start === 1'b1) begin
        if (n_start < 4) st[n_start] = c;
        n_start++;
      end
      if (irq_done === 1'b1) begin n_irq++; irq_at = c; end
      if (c == 50)  ext_trigger = 1'b0;
      if (c == 150) ext_trigger = 1'b1;
    end
    checks++;
    if (n_start != 4) begin errors++; $display("FAIL ext_start_count got %0d exp 4", n_start); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (st[i] != 5 + 100 * i) begin
        errors++; $display("FAIL ext_start_time[%0d] got %0d exp %0d", i, st[i], 5 + 100 * i);
      end
    end
    checks++;
    if (n_irq != 1 || irq_at != 404) begin
      errors++; $display("FAIL ext_irq got count=%0d at=%0d exp count=1 at=404", n_irq, irq_at);
    end
    checks++;
    if (sts_state !== 3'd4) begin errors++; $display("FAIL ext_done state got %0d exp 4", sts_state); end
    cfg_enable = 1'b0;
    tick();
    checks++;
    if (sts_state !== 3'd0) begin errors++; $display("FAIL ext_abort state got %0d exp 0", sts_state); end
    disarm();
  endtask

  task automatic test_rtc();
    int first = -1;
    int n_start = 0;
    int irq_at = -1;
    cfg_mode = 2'd3; cfg_rtc_sec = 32'd0; cfg_rtc_ns = 32'd1_000_000;
    cfg_burst_len = 16'd1; cfg_period = 24'd10; rtc_sec = 32'd0; rtc_ns = 32'd0;
    cfg_enable = 1'b1;
    for (int c = 1; c <= 2530; c++) begin
      tick();
      if (adc_start === 1'b1) begin
        if (first < 0) first = c;
        n_start++;
      end
      if (irq_done === 1'b1) irq_at = c;
      rtc_ns = 32'(400 * c);
    end
    checks++;
    if (first != 2502 || n_start != 1) begin
      errors++; $display("FAIL rtc_fire got first=%0d count=%0d exp first=2502 count=1", first, n_start);
    end
    checks++;
    if (sts_late !== 1'b0) begin errors++; $display("FAIL rtc_not_late got %b exp 0", sts_late); end
    checks++;
    if (irq_at != 2511 || sts_state !== 3'd4) begin
      errors++; $display("FAIL rtc_done got irq_at=%0d state=%0d exp irq_at=2511 state=4", irq_at, sts_state);
    end
    cfg_enable = 1'b0;
    tick();
    cfg_enable = 1'b1;
    first = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (adc_start === 1'b1 && first < 0) first = c;
    end
    checks++;
    if (first != 3) begin errors++; $display("FAIL rtc_late_fire got %0d exp 3", first); end
    checks++;
    if (sts_late !== 1'b1) begin errors++; $display("FAIL rtc_late_flag got %b exp 1", sts_late); end
    disarm();
  endtask

  task automatic test_overrun();
    int st[4];
    int n_start = 0;
    int busy_left = 0;
    int irq_at = -1;
    for (int i = 0; i < 4; i++) st[i] = -1;
    cfg_mode = 2'd1; cfg_burst_len = 16'd4; cfg_period = 24'd10; cfg_enable = 1'b1;
    tick();
    ext_trigger = 1'b1;
    for (int c = 1; c <= 130; c++) begin
      tick();
      if (adc_start === 1'b1) begin
        if (n_start < 4) st[n_start] = c;
        n_start++;
        adc_busy = 1'b1;
        busy_left = 24;
      end else if (busy_left > 0) begin
        busy_left--;
      end else begin
        adc_busy = 1'b0;
      end
      if (irq_done === 1'b1) irq_at = c;
      if (c == 20) begin
        checks++;
        if (sts_state !== 3'd2 || sts_overrun !== 16'd1) begin
          errors++; $display("FAIL ovr_stall got state=%0d ovr=%0d exp state=2 ovr=1", sts_state, sts_overrun);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (st[i] != 5 + 26 * i) begin
        errors++; $display("FAIL ovr_start_time[%0d] got %0d exp %0d", i, st[i], 5 + 26 * i);
      end
    end
    checks++;
    if (sts_overrun !== 16'd4) begin errors++; $display("FAIL ovr_count got %0d exp 4", sts_overrun); end
    checks++;
    if (irq_at != 92 || sts_state !== 3'd4) begin
      errors++; $display("FAIL ovr_done got irq_at=%0d state=%0d exp irq_at=92 state=4", irq_at, sts_state);
    end
    disarm();
  endtask

  task automatic test_continuous();
    int n_start = 0;
    int last = -1;
    int n_irq = 0;
    int n_after = 0;
    cfg_mode = 2'd2; cfg_burst_len = 16'd0; cfg_period = 24'd20; cfg_enable = 1'b1;
    tick();
    ptp_trigger = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (adc_start === 1'b1) begin n_start++; last = c; end
      if (irq_done === 1'b1) n_irq++;
    end
    checks++;
    if (n_start != 15 || last != 285 || n_irq != 0) begin
      errors++; $display("FAIL cont_starts got count=%0d last=%0d irq=%0d exp count=15 last=285 irq=0",
                         n_start, last, n_irq);
    end
    cfg_enable = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (adc_start === 1'b1) n_after++;
    end
    checks++;
    if (n_after != 0 || sts_state !== 3'd0) begin
      errors++; $display("FAIL cont_abort got starts=%0d state=%0d exp starts=0 state=0", n_after, sts_state);
    end
    disarm();
  endtask

`ifdef TRIG_TIMESTAMP_EN
  task automatic test_timestamp();
    cfg_mode = 2'd3; cfg_rtc_sec = 32'd5; cfg_rtc_ns = 32'd100;
    cfg_burst_len = 16'd1; cfg_period = 24'd10; rtc_sec = 32'd5; rtc_ns = 32'd0;
    cfg_enable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      rtc_ns = 32'(40 * c);
    end
    checks++;
    if (ts_sec !== 32'd5 || ts_ns !== 32'd120 || ts_valid !== 1'b1) begin
      errors++; $display("FAIL ts_capture got sec=%0d ns=%0d valid=%b exp sec=5 ns=120 valid=1",
                         ts_sec, ts_ns, ts_valid);
    end
    cfg_enable = 1'b0;
    tick();
    checks++;
    if (ts_valid !== 1'b1) begin errors++; $display("FAIL ts_hold got %b exp 1", ts_valid); end
    cfg_enable = 1'b1;
    tick();
    checks++;
    if (ts_valid !== 1'b0) begin errors++; $display("FAIL ts_rearm_clear got %b exp 0", ts_valid); end
    disarm();
  endtask
`endif

  task automatic test_reset_mid_burst();
    cfg_mode = 2'd1; cfg_burst_len = 16'd0; cfg_period = 24'd50; cfg_enable = 1'b1;
    tick();
    ext_trigger = 1'b1;
    repeat (15) tick();
    checks++;
    if (sts_state !== 3'd3) begin errors++; $display("FAIL mid_gap state got %0d exp 3", sts_state); end
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if ({adc_start, sts_state, sts_late, sts_overrun, irq_done} !== 22'd0) begin
      errors++;
      $display("FAIL mid_reset got start=%b state=%0d late=%b ovr=%0d irq=%b exp all 0",
               adc_start, sts_state, sts_late, sts_overrun, irq_done);
    end
  endtask

  initial begin
    test_reset();
    test_ext_burst();
    test_rtc();
    test_overrun();
    test_continuous();
`ifdef TRIG_TIMESTAMP_EN
    test_timestamp();
`endif
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
